lsu_unit: RTL



---
 rtl/lsu_unit.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_unit.sv
// Load/store unit: forms base+offset addresses, drives the data-memory
// request/grant/response port with lane-aligned byte enables and data,
// optionally splits line-crossing accesses into two beats, and returns one
// extended write-back response per request.
module lsu_unit #(
   parameter int XLEN          = 32,
   parameter int ADDR_W        = 32,
   parameter int MISALIGN_MODE = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [3:0]           req_op_i,
   input  logic [XLEN-1:0]      req_base_i,
   input  logic [XLEN-1:0]      req_offset_i,
   input  logic [XLEN-1:0]      req_wdata_i,
   input  logic [4:0]           req_rd_i,
   output logic                 mem_req_o,
   input  logic                 mem_gnt_i,
   output logic                 mem_we_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [XLEN/8-1:0]    mem_be_o,
   output logic [XLEN-1:0]      mem_wdata_o,
   input  logic                 mem_rvalid_i,
   input  logic [XLEN-1:0]      mem_rdata_i,
   output logic                 rsp_valid_o,
   output logic [XLEN-1:0]      rsp_data_o,
   output logic [4:0]           rsp_rd_o,
   output logic                 rsp_we_o,
   output logic                 rsp_err_o
);
   // state  | meaning
   // IDLE   | waiting for a request, req_ready high
   // REQ0   | first beat requested, waiting for grant
   // WAIT0  | first beat granted, waiting for rvalid
   // REQ1   | second (line-crossing) beat requested
   // WAIT1  | second beat granted, waiting for rvalid
   // RESP   | response is being formed; rsp_valid pulses next cycle

   localparam int BYTES = XLEN / 8;
   localparam int OFF_W = $clog2(BYTES);

   typedef enum logic [2:0] {S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP} state_t;

   state_t              state_q, state_d;
   logic                rdy_en_q;
   logic                store_q, store_d, uns_q, uns_d, cross_q, cross_d, err_q, err_d;
   logic [1:0]          size_q, size_d;
   logic [4:0]          rd_q, rd_d;
   logic [OFF_W-1:0]    off_q, off_d;
   logic [BYTES-1:0]    be1_q, be1_d;
   logic [XLEN-1:0]     wd1_q, wd1_d, rbuf0_q, rbuf0_d, rbuf1_q, rbuf1_d;
   logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [BYTES-1:0]    mem_be_q, mem_be_d;
   logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
   logic                rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d, rsp_err_q, rsp_err_d;
   logic [XLEN-1:0]     rsp_data_q, rsp_data_d;
   logic [4:0]          rsp_rd_q, rsp_rd_d;

   logic [XLEN-1:0]     ea;
   logic [OFF_W-1:0]    acc_off;
   logic [3:0]          acc_n, off4;
   logic                acc_mis, acc_cross, acc_err;
   logic [BYTES-1:0]    acc_mask;
   logic [2*BYTES-1:0]  be_full;
   logic [2*XLEN-1:0]   wd_full, raw_full;
   logic [XLEN-1:0]     raw, ext;
   logic                sbit;
   int                  nbits;

   assign req_ready_o = rdy_en_q && (state_q == S_IDLE);
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_be_o    = mem_be_q;
   assign mem_wdata_o = mem_wdata_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_rd_o    = rsp_rd_q;
   assign rsp_we_o    = rsp_we_q;
   assign rsp_err_o   = rsp_err_q;

   // Address decode, legality and lane placement of the incoming request;
   // the upper half of each double-width shift is the second beat.
   always_comb begin
      ea        = req_base_i + req_offset_i;
      acc_off   = ea[OFF_W-1:0];
      off4      = 4'(acc_off);
      acc_n     = 4'd1 << req_op_i[1:0];
      acc_mis   = (off4 & (acc_n - 4'd1)) != 4'd0;
      acc_cross = (off4 + acc_n) > 4'(BYTES);
      acc_err   = ((req_op_i[1:0] == 2'b11) && (XLEN == 32)) || (acc_mis && (MISALIGN_MODE == 0));
      acc_mask  = '0;
      for (int j = 0; j < BYTES; j++) acc_mask[j] = (j < int'(acc_n));
      be_full   = {{BYTES{1'b0}}, acc_mask} << acc_off;
      wd_full   = {{XLEN{1'b0}}, req_wdata_i} << {acc_off, 3'b000};
   end

   // Load result: pick bytes starting at the offset across both beats, then extend.
   always_comb begin
      raw_full = {rbuf1_q, rbuf0_q} >> {off_q, 3'b000};
      raw      = raw_full[XLEN-1:0];
      case (size_q)
         2'd0:    sbit = raw[7];
         2'd1:    sbit = raw[15];
         2'd2:    sbit = raw[31];
         default: sbit = raw[XLEN-1];
      endcase
      nbits = 8 << size_q;
      ext   = '0;
      for (int i = 0; i < XLEN; i++) ext[i] = (i < nbits) ? raw[i] : (!uns_q && sbit);
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      store_d     = store_q;
      uns_d       = uns_q;
      cross_d     = cross_q;
      err_d       = err_q;
      size_d      = size_q;
      rd_d        = rd_q;
      off_d       = off_q;
      be1_d       = be1_q;
      wd1_d       = wd1_q;
      rbuf0_d     = rbuf0_q;
      rbuf1_d     = rbuf1_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = '0;
      rsp_rd_d    = '0;
      rsp_we_d    = 1'b0;
      rsp_err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i && req_ready_o) begin
               store_d = req_op_i[3];
               uns_d   = req_op_i[2];
               size_d  = req_op_i[1:0];
               rd_d    = req_rd_i;
               off_d   = acc_off;
               cross_d = acc_cross;
               err_d   = acc_err;
               be1_d   = be_full[2*BYTES-1:BYTES];
               wd1_d   = wd_full[2*XLEN-1:XLEN];
               rbuf0_d = '0;
               rbuf1_d = '0;
               if (acc_err) begin
                  state_d = S_RESP;
               end else begin
                  state_d     = S_REQ0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_op_i[3];
                  mem_addr_d  = ea[ADDR_W-1:0] & ~ADDR_W'(BYTES - 1);
                  mem_be_d    = be_full[BYTES-1:0];
                  mem_wdata_d = wd_full[XLEN-1:0];
               end
            end
         end
         S_REQ0: begin
            if (mem_gnt_i) begin
               mem_req_d = 1'b0;
               state_d   = S_WAIT0;
            end
         end
         S_WAIT0: begin
            if (mem_rvalid_i) begin
               rbuf0_d = mem_rdata_i;
               if (cross_q) begin
                  state_d     = S_REQ1;
                  mem_req_d   = 1'b1;
                  mem_addr_d  = mem_addr_q + ADDR_W'(BYTES);
                  mem_be_d    = be1_q;
                  mem_wdata_d = wd1_q;
               end else begin
                  state_d = S_RESP;
               end
            end
         end
         S_REQ1: begin
            if (mem_gnt_i) begin
               mem_req_d = 1'b0;
               state_d   = S_WAIT1;
            end
         end
         S_WAIT1: begin
            if (mem_rvalid_i) begin
               rbuf1_d = mem_rdata_i;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
            rsp_rd_d    = rd_q;
            rsp_err_d   = err_q;
            rsp_we_d    = !err_q && !store_q;
            rsp_data_d  = (err_q || store_q) ? '0 : ext;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset abandons any outstanding access.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         rdy_en_q    <= 1'b0;
         store_q     <= 1'b0;
         uns_q       <= 1'b0;
         cross_q     <= 1'b0;
         err_q       <= 1'b0;
         size_q      <= '0;
         rd_q        <= '0;
         off_q       <= '0;
         be1_q       <= '0;
         wd1_q       <= '0;
         rbuf0_q     <= '0;
         rbuf1_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_rd_q    <= '0;
         rsp_we_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rdy_en_q    <= 1'b1;
         store_q     <= store_d;
         uns_q       <= uns_d;
         cross_q     <= cross_d;
         err_q       <= err_d;
         size_q      <= size_d;
         rd_q        <= rd_d;
         off_q       <= off_d;
         be1_q       <= be1_d;
         wd1_q       <= wd1_d;
         rbuf0_q     <= rbuf0_d;
         rbuf1_q     <= rbuf1_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_rd_q    <= rsp_rd_d;
         rsp_we_q    <= rsp_we_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

endmodule
